// File: rtl/systolic_drain_pkg.sv
// Shared widths and the FIFO entry layout for the systolic result drain.
// The entry struct is sized from the default array geometry below.
package systolic_pkg;

  localparam int D_W_DEF = 8;
  localparam int N_DEF   = 3;
  localparam int M_DEF   = 6;
  localparam int FD_DEF  = 4;

  function automatic int addr_w(input int m);
    return (m * m > 1) ? $clog2(m * m) : 1;
  endfunction

  function automatic int col_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int blk_w(input int m, input int n);
    return (m / n > 1) ? $clog2(m / n) : 1;
  endfunction

  typedef struct packed {
    logic [2*D_W_DEF-1:0]      data;
    logic [addr_w(M_DEF)-1:0]  addr;
  } drain_entry_t;

endpackage

// File: rtl/systolic_drain_if.sv
// Lane capture and result-memory write port of the drain.
// Handshake: a write transfers on any clock edge where wr_en && wr_ready; while wr_en is high
// and wr_ready low, wr_addr/wr_data hold. Lanes have no backpressure: valid_m2 is a strobe.
interface systolic_drain_if
  import systolic_pkg::*;
#(
  parameter int D_W = D_W_DEF,
  parameter int N   = N_DEF,
  parameter int M   = M_DEF
);
  logic                       start;
  logic [N-1:0][2*D_W-1:0]    m2;
  logic [N-1:0]               valid_m2;
  logic                       wr_en;
  logic                       wr_ready;
  logic [addr_w(M)-1:0]       wr_addr;
  logic [2*D_W-1:0]           wr_data;
  logic                       busy;
  logic                       done;
  logic                       overflow;

  modport master (
    output start, m2, valid_m2, wr_ready,
    input  wr_en, wr_addr, wr_data, busy, done, overflow
  );

  modport slave (
    input  start, m2, valid_m2, wr_ready,
    output wr_en, wr_addr, wr_data, busy, done, overflow
  );
endinterface

// File: rtl/systolic_drain_fifo.sv
// Per-lane synchronous FIFO; head is visible combinationally on dout.
// A push into a full FIFO is taken only when the same cycle also pops.
module drain_fifo #(
  parameter int FD = 4,
  parameter int W  = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(FD);

  logic [W-1:0]  mem [FD];
  logic [PW-1:0] wp, rp;
  logic [PW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (PW+1)'(FD));
  assign empty   = (cnt == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (clear) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wp] <= din;
  end
endmodule

// File: rtl/systolic_drain.sv
// Buffers skewed systolic row outputs per lane and serializes them round-robin into the
// row-major result memory; reports busy/done/overflow to the controller.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int D_W = D_W_DEF,
  parameter int N   = N_DEF,
  parameter int M   = M_DEF,
  parameter int FD  = FD_DEF
) (
  input  logic               clk,
  input  logic               rst,
  systolic_drain_if.slave    bus,
  output logic [1:0]         dbg_state
);
  localparam int AW  = addr_w(M);
  localparam int CW  = col_w(M);
  localparam int BW  = blk_w(M, N);
  localparam int LW  = (N > 1) ? $clog2(N) : 1;
  localparam int EW  = $bits(drain_entry_t);
  localparam int WCW = $clog2(M * M + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic          ovf, locked, any_ne, live, wr_en;
  logic [LW-1:0] rr, grant, lock_lane;
  logic [WCW-1:0] wcnt;
  logic [N-1:0]  full, empty, push, pop, drop_full, lane_done;
  drain_entry_t  din  [N];
  drain_entry_t  dout [N];

  assign live = (state == S_BUSY) && !bus.start;

  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [CW-1:0] col;
    logic [BW-1:0] blk;

    assign din[k] = '{data: bus.m2[k], addr: AW'((int'(blk) * N + k) * M + int'(col))};
    assign push[k]      = live && bus.valid_m2[k] && !lane_done[k] && (!full[k] || pop[k]);
    assign drop_full[k] = live && bus.valid_m2[k] && !lane_done[k] && full[k] && !pop[k];

    drain_fifo #(.FD(FD), .W(EW)) u_fifo (
      .clk(clk), .rst(rst), .clear(bus.start),
      .push(push[k]), .pop(pop[k]), .din(din[k]), .dout(dout[k]),
      .full(full[k]), .empty(empty[k])
    );

    // Lane address walks col fastest, then block; the lane retires after its last column.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        col          <= '0;
        blk          <= '0;
        lane_done[k] <= 1'b0;
      end else if (bus.start) begin
        col          <= '0;
        blk          <= '0;
        lane_done[k] <= 1'b0;
      end else if (push[k]) begin
        if (col == CW'(M - 1)) begin
          col <= '0;
          if (blk == BW'(M / N - 1)) lane_done[k] <= 1'b1;
          else                       blk <= blk + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // A stalled grant is locked so a lane filling up ahead of it cannot steal the port.
  always_comb begin
    int idx;
    idx    = 0;
    grant  = lock_lane;
    any_ne = 1'b0;
    if (locked) begin
      any_ne = !empty[lock_lane];
    end else begin
      for (int i = 0; i < N; i++) begin
        idx = (int'(rr) + i) % N;
        if (!any_ne && !empty[idx]) begin
          any_ne = 1'b1;
          grant  = LW'(idx);
        end
      end
    end
  end

  assign wr_en = (state == S_BUSY) && any_ne;

  always_comb begin
    pop = '0;
    if (wr_en && bus.wr_ready) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      ovf       <= 1'b0;
      rr        <= '0;
      locked    <= 1'b0;
      lock_lane <= '0;
      wcnt      <= '0;
    end else if (bus.start) begin
      state     <= S_BUSY;
      ovf       <= 1'b0;
      rr        <= '0;
      locked    <= 1'b0;
      lock_lane <= '0;
      wcnt      <= '0;
    end else begin
      if (|drop_full) ovf <= 1'b1;
      locked    <= wr_en && !bus.wr_ready;
      lock_lane <= grant;
      if (wr_en && bus.wr_ready) begin
        rr   <= (grant == LW'(N - 1)) ? '0 : grant + 1'b1;
        wcnt <= wcnt + 1'b1;
        if (wcnt == WCW'(M * M - 1)) state <= S_DONE;
      end
    end
  end

  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_en ? dout[grant].addr : '0;
  assign bus.wr_data  = wr_en ? dout[grant].data : '0;
  assign bus.busy     = (state == S_BUSY);
  assign bus.done     = (state == S_DONE);
  assign bus.overflow = ovf;
  assign dbg_state    = state;
endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: directed table and sequences plus a randomized run, all
// checked against a lane-queue model of the drain rules.
module tb_systolic_drain;
  localparam int N  = 3;
  localparam int M  = 6;
  localparam int FD = 4;
  localparam int PER_LANE = M * M / N;

  logic       clk, rst;
  logic [1:0] dbg_state;
  int n_pass = 0, n_total = 0;

  systolic_drain_if #(.D_W(8), .N(N), .M(M)) bus ();

  systolic_drain #(.D_W(8), .N(N), .M(M), .FD(FD)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: one expected queue per lane of {addr, data}
  logic [21:0] exp_q [N][$];
  int m_cnt [N];
  int m_rr, m_held, m_wcnt;
  logic m_busy, m_done, m_ovf;
  int seen [64];

  // Observations of the most recent cycle
  logic obs_en, obs_busy, obs_done, obs_ovf;
  logic [5:0] obs_addr;
  logic [15:0] obs_data;
  int cyc = 0, n_wr = 0, last_wr_cyc = 0;
  logic [5:0] addr_0205;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete();
      m_cnt[k] = 0;
    end
    for (int a = 0; a < 64; a++) seen[a] = 0;
    m_rr = 0; m_held = -1; m_wcnt = 0;
    m_done = 1'b0; m_ovf = 1'b0;
  endtask

  // Drives one cycle at posedge+1, checks at negedge, advances the model, returns at next posedge+1
  task automatic cycle(input logic st, input logic [2:0] v, input logic [15:0] d0,
                       input logic [15:0] d1, input logic [15:0] d2, input logic rdy);
    int lane;
    logic [21:0] e;
    logic [15:0] d [N];
    d[0] = d0; d[1] = d1; d[2] = d2;
    bus.start = st; bus.valid_m2 = v; bus.wr_ready = rdy;
    bus.m2[0] = d0; bus.m2[1] = d1; bus.m2[2] = d2;
    @(negedge clk);
    cyc++;
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    obs_en = bus.wr_en; obs_addr = bus.wr_addr; obs_data = bus.wr_data;
    obs_busy = bus.busy; obs_done = bus.done; obs_ovf = bus.overflow;
    lane = m_held;
    if (lane < 0)
      for (int i = 0; i < N; i++)
        if (lane < 0 && exp_q[(m_rr + i) % N].size() > 0) lane = (m_rr + i) % N;
    if (lane < 0) begin
      chk("wr_en_idle", 32'(bus.wr_en), 32'd0);
    end else begin
      e = exp_q[lane][0];
      chk("wr_en", 32'(bus.wr_en), 32'd1);
      chk("wr_addr", 32'(bus.wr_addr), 32'(e[21:16]));
      chk("wr_data", 32'(bus.wr_data), 32'(e[15:0]));
    end
    if (bus.wr_en && rdy) begin
      n_wr++; last_wr_cyc = cyc;
      if (bus.wr_data == 16'h0205) addr_0205 = bus.wr_addr;
    end
    // Model update: pop first so a full lane may accept in the same cycle
    if (lane >= 0 && rdy) begin
      e = exp_q[lane].pop_front();
      seen[e[21:16]]++;
      m_rr = (lane + 1) % N; m_held = -1; m_wcnt++;
    end else if (lane >= 0) begin
      m_held = lane;
    end
    if (st) begin
      model_clear();
      m_busy = 1'b1;
    end else if (m_busy) begin
      for (int k = 0; k < N; k++)
        if (v[k] && m_cnt[k] < PER_LANE) begin
          if (exp_q[k].size() < FD) begin
            exp_q[k].push_back({6'(((m_cnt[k] / M) * N + k) * M + m_cnt[k] % M), d[k]});
            m_cnt[k]++;
          end else begin
            m_ovf = 1'b1;
          end
        end
      if (m_wcnt == M * M) begin
        m_busy = 1'b0; m_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic st; logic [2:0] v; logic rdy;
    logic exp_en; logic [5:0] exp_addr; logic [15:0] exp_data;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int bad, base, wcount;
    logic [2:0] rv;
    model_clear();
    m_busy = 1'b0;
    rst = 1'b0;
    bus.start = 1'b0; bus.valid_m2 = 3'b111; bus.wr_ready = 1'b1;
    bus.m2[0] = 16'h1111; bus.m2[1] = 16'h2222; bus.m2[2] = 16'h3333;

    // 1: reset with all lanes valid
    @(negedge clk); @(negedge clk);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'b111, 16'h1, 16'h2, 16'h3, 1'b1);
    chk("idle_no_write", 32'(n_wr), 32'd0);

    // 3: simultaneous lanes drain in round-robin order
    tbl[0] = '{1'b1, 3'b000, 1'b1, 1'b0, 6'd0,  16'h0000};
    tbl[1] = '{1'b0, 3'b111, 1'b1, 1'b0, 6'd0,  16'h0000};
    tbl[2] = '{1'b0, 3'b000, 1'b1, 1'b1, 6'd0,  16'h0000};
    tbl[3] = '{1'b0, 3'b000, 1'b1, 1'b1, 6'd6,  16'h0100};
    tbl[4] = '{1'b0, 3'b000, 1'b1, 1'b1, 6'd12, 16'h0200};
    tbl[5] = '{1'b0, 3'b000, 1'b1, 1'b0, 6'd0,  16'h0000};
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].st, tbl[i].v, 16'h0000, 16'h0100, 16'h0200, tbl[i].rdy);
      chk("rr_en", 32'(obs_en), 32'(tbl[i].exp_en));
      if (tbl[i].exp_en) begin
        chk("rr_addr", 32'(obs_addr), 32'(tbl[i].exp_addr));
        chk("rr_data", 32'(obs_data), 32'(tbl[i].exp_data));
      end
    end

    // 2: full collection, lanes skewed by one cycle and interleaved at the port rate
    addr_0205 = '1;
    cycle(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    base = n_wr;
    for (int c = 0; c < M * M; c++)
      cycle(1'b0, 3'(1 << (c % N)), 16'h0000 + 16'((c / N) % M), 16'h0100 + 16'((c / N) % M),
            16'h0200 + 16'((c / N) % M), 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
      if (obs_done) break;
    end
    chk("full_done", 32'(obs_done), 32'd1);
    chk("done_latency", 32'(cyc - last_wr_cyc), 32'd1);
    chk("full_writes", 32'(n_wr - base), 32'd36);
    bad = 0;
    for (int a = 0; a < M * M; a++) if (seen[a] != 1) bad++;
    chk("addr_once", 32'(bad), 32'd0);
    chk("lane2_last_addr", 32'(addr_0205), 32'd35);
    chk("full_overflow", 32'(obs_ovf), 32'd0);

    // 4: stall with lane 0 streaming into a full FIFO
    cycle(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 3'b001, 16'hA000 + 16'(i), 16'h0, 16'h0, 1'b0);
      if (i >= 1 && (!obs_en || obs_addr != 6'd0 || obs_data != 16'hA000)) bad++;
      if (i == 4) chk("ovf_before_5th", 32'(obs_ovf), 32'd0);
      if (i == 5) chk("ovf_after_5th", 32'(obs_ovf), 32'd1);
    end
    chk("stall_stable", 32'(bad), 32'd0);
    base = n_wr;
    for (int i = 0; i < 8; i++) cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    chk("lane0_after_stall", 32'(n_wr - base), 32'd4);

    // 5: restart mid-collection
    cycle(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    base = n_wr;
    for (int c = 0; c < 60; c++) begin
      if (n_wr - base >= 10) break;
      cycle(1'b0, 3'(1 << (c % N)), 16'h0010 + 16'(c), 16'h0110 + 16'(c), 16'h0210 + 16'(c), 1'b1);
    end
    chk("ten_writes", 32'(n_wr - base), 32'd10);
    for (int i = 0; i < 5; i++) cycle(1'b0, 3'b001, 16'hB000 + 16'(i), 16'h0, 16'h0, 1'b0);
    cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("pre_restart_ovf", 32'(obs_ovf), 32'd1);
    cycle(1'b1, 3'b111, 16'hEEEE, 16'hEEEE, 16'hEEEE, 1'b1);
    cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    chk("restart_ovf", 32'(obs_ovf), 32'd0);
    chk("restart_done", 32'(obs_done), 32'd0);
    chk("restart_busy", 32'(obs_busy), 32'd1);
    chk("restart_flushed", 32'(obs_en), 32'd0);
    cycle(1'b0, 3'b001, 16'h5A5A, 16'h0, 16'h0, 1'b1);
    cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    chk("restart_en", 32'(obs_en), 32'd1);
    chk("restart_addr", 32'(obs_addr), 32'd0);
    chk("restart_data", 32'(obs_data), 32'h5A5A);

    // 6: asynchronous reset while a write is pending
    cycle(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0);
    cycle(1'b0, 3'b001, 16'h1234, 16'h0, 16'h0, 1'b0);
    cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b0);
    chk("pre_reset_en", 32'(obs_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_en", 32'(bus.wr_en), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    model_clear();
    m_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    base = n_wr;
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'b111, 16'h7, 16'h8, 16'h9, 1'b1);
    chk("post_reset_no_write", 32'(n_wr - base), 32'd0);

    // Randomized: lane collisions, back-pressure, full-FIFO push/pop, late valids
    cycle(1'b1, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    base = n_wr;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) rv[k] = ($urandom_range(0, 99) < 35);
      cycle(1'b0, rv, 16'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 200; i++) begin
      if (obs_done) break;
      cycle(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    end
    chk("rand_done", 32'(obs_done), 32'd1);
    wcount = n_wr - base;
    chk("rand_writes", 32'(wcount), 32'd36);
    bad = 0;
    for (int a = 0; a < M * M; a++) if (seen[a] != 1) bad++;
    chk("rand_addr_once", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
